// File: rtl/rc4_pkg.sv
// rtl/rc4_pkg.sv - shared RC4 types and constants for the encryptor and decryptor
package rc4_pkg;

    localparam int RC4_BYTE_W = 8;

    typedef enum logic [3:0] {
        AWAIT_START,
        COMPUTE_I,
        READ_SI,
        READ_SJ,
        SET_SI,
        SET_SJ,
        AWAIT_KS,
        LATCH_KS,
        AWAIT_PT,
        EMIT,
        DONE
    } state_t;

endpackage

// File: rtl/edge_detector.sv
// rtl/edge_detector.sv - registered rising-edge pulse generator for a level input
module edge_detector (
    input  logic clk,
    input  logic reset_n,
    input  logic level,
    output logic rise
);

    logic level_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            level_q <= 1'b0;
            rise    <= 1'b0;
        end else begin
            level_q <= level;
            rise    <= level & ~level_q;
        end
    end

endmodule

// File: rtl/rc4_stream_encryptor.sv
// rtl/rc4_stream_encryptor.sv - streaming RC4 PRGA encryptor over a shared single-port S RAM
module rc4_stream_encryptor
    import rc4_pkg::*;
#(
    parameter int RAM_WIDTH          = RC4_BYTE_W,
    parameter int RAM_LENGTH         = 8,
    parameter int MESSAGE_LENGTH     = 32,
    parameter int MESSAGE_LOG_LENGTH = 5
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          start,
    input  logic [RAM_WIDTH-1:0]          sOut,
    output logic [RAM_WIDTH-1:0]          sIn,
    output logic [RAM_LENGTH-1:0]         sAddr,
    output logic                          sWren,
    input  logic [RAM_WIDTH-1:0]          ptData,
    input  logic                          ptValid,
    output logic                          ptReady,
    output logic [RAM_WIDTH-1:0]          ctData,
    output logic                          ctValid,
    input  logic                          ctReady,
    output logic                          ctLast,
    output logic                          busy,
    output logic                          finished,
    output logic [MESSAGE_LOG_LENGTH-1:0] byteCount
);

    state_t                  state, state_n;
    logic [RAM_LENGTH-1:0]   i, j;
    logic [RAM_WIDTH-1:0]    si, sj, ks, ct;
    logic                    start_rise;
    logic                    last_byte;

    edge_detector u_start_edge (
        .clk     (clk),
        .reset_n (reset_n),
        .level   (start),
        .rise    (start_rise)
    );

    assign last_byte = (byteCount == MESSAGE_LOG_LENGTH'(MESSAGE_LENGTH - 1));

    // Every output decodes registered state only; ptValid/ctReady just steer the next state.
    assign ptReady  = (state == AWAIT_PT);
    assign ctValid  = (state == EMIT);
    assign ctData   = (state == EMIT) ? ct : '0;
    assign ctLast   = (state == EMIT) && last_byte;
    assign busy     = (state != AWAIT_START);
    assign finished = (state == DONE);

    always_comb begin
        state_n = state;
        case (state)
            AWAIT_START: if (start_rise) state_n = COMPUTE_I;
            COMPUTE_I:   state_n = READ_SI;
            READ_SI:     state_n = READ_SJ;
            READ_SJ:     state_n = SET_SI;
            SET_SI:      state_n = SET_SJ;
            SET_SJ:      state_n = AWAIT_KS;
            AWAIT_KS:    state_n = LATCH_KS;
            LATCH_KS:    state_n = AWAIT_PT;
            AWAIT_PT:    if (ptValid) state_n = EMIT;
            EMIT:        if (ctReady) state_n = last_byte ? DONE : COMPUTE_I;
            DONE:        state_n = AWAIT_START;
            default:     state_n = AWAIT_START;
        endcase
    end

    // SET_SJ writes after SET_SI, so when i == j the location ends up holding si.
    always_comb begin
        sAddr = '0;
        sIn   = '0;
        sWren = 1'b0;
        case (state)
            COMPUTE_I: sAddr = i + RAM_LENGTH'(1);
            READ_SI:   sAddr = j + RAM_LENGTH'(sOut);
            READ_SJ:   sAddr = i;
            SET_SI: begin
                sAddr = i;
                sIn   = sj;
                sWren = 1'b1;
            end
            SET_SJ: begin
                sAddr = j;
                sIn   = si;
                sWren = 1'b1;
            end
            AWAIT_KS:  sAddr = RAM_LENGTH'(si) + RAM_LENGTH'(sj);
            default:   sAddr = '0;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= AWAIT_START;
            i         <= '0;
            j         <= '0;
            si        <= '0;
            sj        <= '0;
            ks        <= '0;
            ct        <= '0;
            byteCount <= '0;
        end else begin
            state <= state_n;
            case (state)
                COMPUTE_I: i <= i + RAM_LENGTH'(1);
                READ_SI: begin
                    si <= sOut;
                    j  <= j + RAM_LENGTH'(sOut);
                end
                READ_SJ:  sj <= sOut;
                LATCH_KS: ks <= sOut;
                AWAIT_PT: if (ptValid) ct <= ptData ^ ks;
                EMIT:     if (ctReady && !last_byte) byteCount <= byteCount + MESSAGE_LOG_LENGTH'(1);
                DONE: begin
                    i         <= '0;
                    j         <= '0;
                    si        <= '0;
                    sj        <= '0;
                    ks        <= '0;
                    byteCount <= '0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc4_stream_encryptor.sv
// tb/tb_rc4_stream_encryptor.sv - scoreboard bench for rc4_stream_encryptor with a behavioural S RAM
module tb_rc4_stream_encryptor;

    localparam int ML = 9;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic [7:0] sOut, sIn, sAddr;
    logic       sWren;
    logic [7:0] ptData = 8'h00;
    logic       ptValid = 1'b0;
    logic       ptReady;
    logic [7:0] ctData;
    logic       ctValid, ctLast, busy, finished;
    logic       ctReady = 1'b1;
    logic [3:0] byteCount;

    always #5 clk = ~clk;

    rc4_stream_encryptor #(
        .RAM_WIDTH(8), .RAM_LENGTH(8), .MESSAGE_LENGTH(ML), .MESSAGE_LOG_LENGTH(4)
    ) dut (
        .clk(clk), .reset_n(reset_n), .start(start),
        .sOut(sOut), .sIn(sIn), .sAddr(sAddr), .sWren(sWren),
        .ptData(ptData), .ptValid(ptValid), .ptReady(ptReady),
        .ctData(ctData), .ctValid(ctValid), .ctReady(ctReady), .ctLast(ctLast),
        .busy(busy), .finished(finished), .byteCount(byteCount)
    );

    // S RAM: synchronous read, bulk load from s_init while the DUT is idle
    logic [7:0] s_mem  [256];
    logic [7:0] s_init [256];
    logic       load_s = 1'b0;

    always @(posedge clk) begin
        if (load_s) begin
            for (int k = 0; k < 256; k++) s_mem[k] <= s_init[k];
        end else if (sWren) begin
            s_mem[sAddr] <= sIn;
        end
        sOut <= s_mem[sAddr];
    end

    logic [7:0] pt_std [ML] = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
    logic [7:0] ct_std [ML] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3};
    logic [7:0] ks_id  [ML] = '{8'h02, 8'h05, 8'h07, 8'h0D, 8'h0D, 8'h17, 8'h1F, 8'h28, 8'h28};

    typedef struct packed {
        logic [7:0] data;
        logic       last;
        logic [3:0] idx;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] pt_q  [$];
    exp_t       mon_e;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    int start_cyc = 0;
    int ct_idx = 0;
    int stall_extra = 0;
    int fin_count = 0;
    int fin_cyc = 0;
    logic pt_fire = 1'b0;
    logic stall_q = 1'b0;
    logic [7:0] hold_data = 8'h00;
    logic hold_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        n_cmp++;
        n_fail++;
        $display("FAIL %s: bound expired before the expected event", name);
    endtask

    always @(posedge clk) cyc++;

    // Plaintext source: handshake observed at negedge, data advanced just after the edge
    always @(negedge clk) pt_fire = ptValid && ptReady;

    always @(posedge clk) begin
        #1;
        if (pt_fire && pt_q.size() > 0) pt_q.delete(0);
        pt_fire = 1'b0;
        ptValid = (pt_q.size() > 0);
        ptData  = (pt_q.size() > 0) ? pt_q[0] : 8'h00;
    end

    // Monitor: pops the scoreboard on every ciphertext handshake
    always @(negedge clk) begin
        if (!reset_n) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q && ctValid) begin
                chk("hold_data", ctData, hold_data);
                chk("hold_last", ctLast, hold_last);
            end
            if (ctValid && ctReady) begin
                if (exp_q.size() == 0) begin
                    fail("unexpected_ct");
                end else begin
                    mon_e = exp_q.pop_front();
                    chk($sformatf("ct_data[%0d]", mon_e.idx), ctData, mon_e.data);
                    chk($sformatf("ct_last[%0d]", mon_e.idx), ctLast, mon_e.last);
                    chk($sformatf("byte_count[%0d]", mon_e.idx), byteCount, mon_e.idx);
                    chk($sformatf("ct_cycle[%0d]", ct_idx), cyc - start_cyc, 10 + 9 * ct_idx + stall_extra);
                    ct_idx++;
                end
            end
            stall_q   = ctValid && !ctReady;
            hold_data = ctData;
            hold_last = ctLast;
            if (finished) begin
                fin_count++;
                fin_cyc = cyc - start_cyc;
            end
        end
    end

    task automatic load_ram();
        @(negedge clk);
        load_s = 1'b1;
        @(negedge clk);
        load_s = 1'b0;
    endtask

    task automatic load_key();
        logic [7:0] key [3];
        logic [7:0] jj, t;
        key[0] = 8'h4B;
        key[1] = 8'h65;
        key[2] = 8'h79;
        for (int k = 0; k < 256; k++) s_init[k] = k[7:0];
        jj = 8'h00;
        for (int k = 0; k < 256; k++) begin
            jj = jj + s_init[k] + key[k % 3];
            t = s_init[k];
            s_init[k] = s_init[jj];
            s_init[jj] = t;
        end
        load_ram();
    endtask

    task automatic load_identity();
        for (int k = 0; k < 256; k++) s_init[k] = k[7:0];
        load_ram();
    endtask

    task automatic push_msg(input bit identity);
        for (int k = 0; k < ML; k++) begin
            pt_q.push_back(identity ? 8'h00 : pt_std[k]);
            exp_q.push_back('{data: (identity ? ks_id[k] : ct_std[k]), last: (k == ML - 1), idx: k[3:0]});
        end
    endtask

    task automatic start_msg();
        @(negedge clk);
        ct_idx = 0;
        fin_count = 0;
        start_cyc = cyc;
        start = 1'b1;
    endtask

    task automatic wait_done(input string name, input int exp_cyc);
        bit got = 1'b0;
        for (int t = 0; t < 300; t++) begin
            @(negedge clk);
            #1;
            if (fin_count > 0) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail({name, "_finished"});
        else chk({name, "_fin_cycle"}, fin_cyc, exp_cyc);
        repeat (3) @(negedge clk);
        #1;
        chk({name, "_fin_pulses"}, fin_count, 1);
        chk({name, "_ct_left"}, exp_q.size(), 0);
    endtask

    task automatic chk_idle(input string name);
        chk({name, "_busy"}, busy, 0);
        chk({name, "_ctValid"}, ctValid, 0);
        chk({name, "_ptReady"}, ptReady, 0);
        chk({name, "_finished"}, finished, 0);
        chk({name, "_sWren"}, sWren, 0);
        chk({name, "_sAddr"}, sAddr, 0);
        chk({name, "_ctData"}, ctData, 0);
        chk({name, "_byteCount"}, byteCount, 0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit busy_seen;
        bit got;

        repeat (3) @(negedge clk);
        #1;
        chk_idle("reset");
        reset_n = 1'b1;
        @(negedge clk);
        #1;
        chk_idle("post_reset");
        chk("post_reset_ctLast", ctLast, 0);

        // Standard vector, full throughput
        load_key();
        push_msg(1'b0);
        start_msg();
        wait_done("std", 83);
        start = 1'b0;

        // Backpressure on byte 0
        load_key();
        push_msg(1'b0);
        ctReady = 1'b0;
        stall_extra = 5;
        start_msg();
        got = 1'b0;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            #1;
            if (ctValid) begin
                got = 1'b1;
                break;
            end
        end
        if (!got) fail("bp_first_valid");
        repeat (5) @(posedge clk);
        #1;
        ctReady = 1'b1;
        wait_done("bp", 88);
        stall_extra = 0;
        start = 1'b0;

        // Identity S, zero plaintext: ciphertext is the raw keystream
        load_identity();
        push_msg(1'b1);
        start_msg();
        wait_done("ident", 83);
        start = 1'b0;

        // start retoggled mid-message, then held high across DONE
        load_key();
        push_msg(1'b0);
        start_msg();
        repeat (15) @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        start = 1'b1;
        wait_done("retoggle", 83);
        busy_seen = 1'b0;
        for (int t = 0; t < 40; t++) begin
            @(negedge clk);
            #1;
            if (busy) busy_seen = 1'b1;
        end
        chk("held_start_busy", busy_seen, 0);
        chk("held_start_fin", fin_count, 1);
        start = 1'b0;

        // Reset mid-message, then a clean restart
        load_key();
        push_msg(1'b0);
        start_msg();
        repeat (30) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk_idle("mid_reset");
        exp_q.delete();
        pt_q.delete();
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        load_key();
        push_msg(1'b0);
        start_msg();
        wait_done("restart", 83);
        start = 1'b0;

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
        $finish;
    end

endmodule
